// File: rtl/jc_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// jc_scan_ctrl : prescaled Johnson-counter scan controller (IDLE/RUN/FIN).
// Optional ping-pong mode is enabled by defining JC_SCAN_CTRL_BOUNCE_EN.
// Revision : 1.0
// ============================================================================
module jc_scan_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIVW  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             STOP,
    input  logic             LEFT,
    input  logic             BOUNCE,
    input  logic [7:0]       STEPS,
    input  logic [DIVW-1:0]  DIV,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIR_OUT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              dir_q, dir_d;
    logic [7:0]        rem_q, rem_d;
    logic [7:0]        steps_q, steps_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [DIVW-1:0]   pre_q, pre_d;
    logic              w_bounce;
    logic              w_launch;
    logic [WIDTH-1:0]  w_step;

    assign w_launch = (state_q == S_IDLE) && START && (STEPS != 8'd0);
    assign w_step   = dir_q ? {q_q[WIDTH-2:0], ~q_q[WIDTH-1]}
                            : {~q_q[0], q_q[WIDTH-1:1]};

`ifdef JC_SCAN_CTRL_BOUNCE_EN
    logic bounce_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bounce_q <= 1'b0;
        end else if (w_launch) begin
            bounce_q <= BOUNCE;
        end
    end

    assign w_bounce = bounce_q;
`else
    logic unused_bounce;
    assign unused_bounce = BOUNCE;
    assign w_bounce      = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            dir_q   <= 1'b0;
            rem_q   <= 8'd0;
            steps_q <= 8'd0;
            div_q   <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            steps_q <= steps_d;
            div_q   <= div_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        steps_d = steps_q;
        div_d   = div_q;
        pre_d   = pre_q;
        case (state_q)
            S_IDLE: begin
                if (w_launch) begin
                    rem_d   = STEPS;
                    steps_d = STEPS;
                    dir_d   = LEFT;
                    div_d   = DIV;
                    pre_d   = '0;
                    state_d = S_RUN;
                end else if (START) begin
                    state_d = S_FIN;
                end
            end
            S_RUN: begin
                // STOP wins over a coincident tick: no step on the abort edge.
                if (STOP) begin
                    state_d = S_FIN;
                end else if (pre_q == div_q) begin
                    pre_d = '0;
                    q_d   = w_step;
                    if (rem_q != 8'd0) begin
                        rem_d = rem_q - 8'd1;
                    end
                    if (rem_q == 8'd1) begin
                        if (w_bounce) begin
                            dir_d = ~dir_q;
                            rem_d = steps_q;
                        end else begin
                            state_d = S_FIN;
                        end
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Q       = q_q;
    assign DIR_OUT = dir_q;
    assign BUSY    = (state_q == S_RUN);
    assign DONE    = (state_q == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_jc_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_jc_scan_ctrl : scoreboard bench for jc_scan_ctrl (WIDTH=4, DIVW=8).
// Revision : 1.0
// ============================================================================
module tb_jc_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       left;
    logic       bounce;
    logic [7:0] steps;
    logic [7:0] div;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       dir_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard entry: {q[3:0], busy, done, dir}
    logic [6:0] sb[$];
    logic [3:0] mq;
    logic       mdir;

    jc_scan_ctrl #(.WIDTH(4), .DIVW(8)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .START  (start),
        .STOP   (stop),
        .LEFT   (left),
        .BOUNCE (bounce),
        .STEPS  (steps),
        .DIV    (div),
        .Q      (q),
        .BUSY   (busy),
        .DONE   (done),
        .DIR_OUT(dir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] mstep(input logic [3:0] v, input logic l);
        return l ? {v[2:0], ~v[3]} : {~v[0], v[3:1]};
    endfunction

    // Pushes the per-cycle expectation of a run, one entry per edge after START.
    task automatic build(input logic l, input int n, input int dv, input logic b, input int stop_at);
        int rem;
        logic eb;
`ifdef JC_SCAN_CTRL_BOUNCE_EN
        eb = b;
`else
        eb = 1'b0;
`endif
        if (n == 0) begin
            sb.push_back({mq, 1'b0, 1'b1, mdir});
            sb.push_back({mq, 1'b0, 1'b0, mdir});
            return;
        end
        mdir = l;
        rem  = n;
        sb.push_back({mq, 1'b1, 1'b0, mdir});
        for (int k = 1; k < 2000; k++) begin
            if (k == stop_at) begin
                sb.push_back({mq, 1'b0, 1'b1, mdir});
                break;
            end
            if (k % (dv + 1) == 0) begin
                mq  = mstep(mq, mdir);
                rem = rem - 1;
                if (rem == 0 && !eb) begin
                    sb.push_back({mq, 1'b0, 1'b1, mdir});
                    break;
                end
                if (rem == 0) begin
                    mdir = ~mdir;
                    rem  = n;
                end
            end
            sb.push_back({mq, 1'b1, 1'b0, mdir});
        end
        sb.push_back({mq, 1'b0, 1'b0, mdir});
    endtask

    task automatic drive_start(input logic l, input logic [7:0] n, input logic [7:0] dv, input logic b);
        left   = l;
        steps  = n;
        div    = dv;
        bounce = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst_n = 1'b0; start = 0; stop = 0; left = 0; bounce = 0; steps = 0; div = 0;
        mq = 4'd0; mdir = 1'b0;
        #22;
        obs = {q, busy, done, dir_out};
        n_cmp++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_held: got %b want %b", obs, 7'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        obs = {q, busy, done, dir_out};
        n_cmp++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", obs, 7'd0);
        end
    endtask

    task automatic test_left_run();
        logic [6:0] e, obs;
        build(1'b1, 8, 0, 1'b0, 0);
        drive_start(1'b1, 8'd8, 8'd0, 1'b0);
        for (int i = 0; sb.size() != 0; i++) begin
            e   = sb.pop_front();
            obs = {q, busy, done, dir_out};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL left_run[%0d]: got q=%b busy=%b done=%b dir=%b want q=%b busy=%b done=%b dir=%b",
                         i, obs[6:3], obs[2], obs[1], obs[0], e[6:3], e[2], e[1], e[0]);
            end
            tick();
        end
    endtask

    task automatic test_right_div();
        logic [6:0] e, obs;
        build(1'b0, 3, 2, 1'b0, 0);
        drive_start(1'b0, 8'd3, 8'd2, 1'b0);
        for (int i = 0; sb.size() != 0; i++) begin
            e   = sb.pop_front();
            obs = {q, busy, done, dir_out};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL right_div[%0d]: got q=%b busy=%b done=%b dir=%b want q=%b busy=%b done=%b dir=%b",
                         i, obs[6:3], obs[2], obs[1], obs[0], e[6:3], e[2], e[1], e[0]);
            end
            if (i == 0) begin
                left = 1'b1; div = 8'd0; steps = 8'd1; bounce = 1'b1;
            end
            tick();
        end
        left = 1'b0; div = 8'd0; steps = 8'd0; bounce = 1'b0;
    endtask

    task automatic test_zero_steps();
        logic [6:0] e, obs;
        build(1'b1, 0, 0, 1'b0, 0);
        drive_start(1'b1, 8'd0, 8'd0, 1'b0);
        for (int i = 0; sb.size() != 0; i++) begin
            e   = sb.pop_front();
            obs = {q, busy, done, dir_out};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL zero_steps[%0d]: got q=%b busy=%b done=%b dir=%b want q=%b busy=%b done=%b dir=%b",
                         i, obs[6:3], obs[2], obs[1], obs[0], e[6:3], e[2], e[1], e[0]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] obs;
        drive_start(1'b1, 8'd8, 8'd3, 1'b0);
        repeat (5) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        obs = {q, busy, done, dir_out};
        n_cmp++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want %b", obs, 7'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq = 4'd0; mdir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {q, busy, done, dir_out};
            n_cmp++;
            if (obs !== 7'd0) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: got %b want %b", i, obs, 7'd0);
            end
        end
    endtask

    task automatic test_stop();
        logic [6:0] e, obs;
        build(1'b1, 8, 0, 1'b0, 4);
        drive_start(1'b1, 8'd8, 8'd0, 1'b0);
        for (int i = 0; sb.size() != 0; i++) begin
            e   = sb.pop_front();
            obs = {q, busy, done, dir_out};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL stop[%0d]: got q=%b busy=%b done=%b dir=%b want q=%b busy=%b done=%b dir=%b",
                         i, obs[6:3], obs[2], obs[1], obs[0], e[6:3], e[2], e[1], e[0]);
            end
            stop  = (i + 1 == 4);
            start = (i + 1 == 2);
            tick();
        end
        stop = 1'b0; start = 1'b0;
    endtask

    task automatic test_bounce();
        logic [6:0] e, obs;
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        mq = 4'd0; mdir = 1'b0;
        tick();
`ifdef JC_SCAN_CTRL_BOUNCE_EN
        build(1'b1, 2, 0, 1'b1, 9);
`else
        build(1'b1, 2, 0, 1'b1, 0);
`endif
        drive_start(1'b1, 8'd2, 8'd0, 1'b1);
        for (int i = 0; sb.size() != 0; i++) begin
            e   = sb.pop_front();
            obs = {q, busy, done, dir_out};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL bounce[%0d]: got q=%b busy=%b done=%b dir=%b want q=%b busy=%b done=%b dir=%b",
                         i, obs[6:3], obs[2], obs[1], obs[0], e[6:3], e[2], e[1], e[0]);
            end
`ifdef JC_SCAN_CTRL_BOUNCE_EN
            stop = (i + 1 == 9);
`endif
            tick();
        end
        stop = 1'b0; bounce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_left_run();
        test_right_div();
        test_zero_steps();
        test_async_reset();
        test_left_run();
        test_stop();
        test_bounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
